// File: rtl/local_history_table_mp_pkg.sv
// Shared types and index helper for the local branch history table.
// Latency: none (types/functions only); backpressure: n/a.
package lht_pkg;

    typedef enum logic {
        LHT_INIT = 1'b0,
        LHT_RUN  = 1'b1
    } lht_state_e;

    // Caller narrows the result to its own index width.
    function automatic logic [31:0] lht_idx(input logic [31:0] pc,
                                            input int unsigned lsb,
                                            input int unsigned idx_w);
        logic [31:0] mask;
        mask = (idx_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << idx_w) - 32'd1);
        return (pc >> lsb) & mask;
    endfunction

endpackage

// File: rtl/local_history_table_mp_if.sv
// Lookup/update/clear bundle between fetch, resolve and the history table.
// Latency: n/a; backpressure: none, ready only qualifies lookups and updates.
interface local_history_table_mp_if #(
    parameter int NUM_RD = 2,
    parameter int HIST_W = 10
);
    logic                           clear_req;
    logic [NUM_RD-1:0][31:0]        rd_pc;
    logic [NUM_RD-1:0][HIST_W-1:0]  rd_hist;
    logic                           upd_valid;
    logic [31:0]                    upd_pc;
    logic                           upd_taken;
    logic                           ready;

    modport master (
        output clear_req, rd_pc, upd_valid, upd_pc, upd_taken,
        input  rd_hist, ready
    );

    modport slave (
        input  clear_req, rd_pc, upd_valid, upd_pc, upd_taken,
        output rd_hist, ready
    );
endinterface

// File: rtl/local_history_table_mp_clear_fsm.sv
// Clear sequencer: sweeps one table entry per cycle after reset or clear_req.
// Latency: ENTRIES cycles per sweep; backpressure: ready low for the whole sweep.
module lht_clear_fsm
    import lht_pkg::*;
#(
    parameter int ENTRIES = 1024,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear_req,
    output logic             o_clr_we,
    output logic [IDX_W-1:0] o_clr_idx,
    output logic             o_ready
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    lht_state_e       r_state;
    lht_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_clr_idx;
    logic [IDX_W-1:0] w_clr_idx_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= LHT_INIT;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            LHT_INIT: begin
                // clear_req mid-sweep restarts from entry 0
                if (i_clear_req) begin
                    w_clr_idx_nxt = '0;
                end else if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt   = LHT_RUN;
                    w_clr_idx_nxt = '0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
                end
            end
            LHT_RUN: begin
                if (i_clear_req) begin
                    w_state_nxt   = LHT_INIT;
                    w_clr_idx_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = LHT_INIT;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    always_comb begin
        o_clr_we  = (r_state == LHT_INIT);
        o_clr_idx = r_clr_idx;
        o_ready   = (r_state == LHT_RUN);
    end

endmodule

// File: rtl/local_history_table_mp.sv
// Multi-read local branch history table: NUM_RD lookups, one shift update per cycle.
// Latency: lookup 0 cycles, update visible next cycle; backpressure: none, updates dropped while not ready.
module local_history_table_mp
    import lht_pkg::*;
#(
    parameter int ENTRIES = 1024,
    parameter int HIST_W  = 10,
    parameter int NUM_RD  = 2,
    parameter int IDX_LSB = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    local_history_table_mp_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [HIST_W-1:0] r_table [ENTRIES];

    logic              w_clr_we;
    logic [IDX_W-1:0]  w_clr_idx;
    logic              w_ready;
    logic              w_upd_we;
    logic [IDX_W-1:0]  w_upd_idx;
    logic [HIST_W-1:0] w_upd_hist;

    lht_clear_fsm #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_clear_fsm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear_req (bus.clear_req),
        .o_clr_we    (w_clr_we),
        .o_clr_idx   (w_clr_idx),
        .o_ready     (w_ready)
    );

    assign bus.ready = w_ready;
    assign w_upd_we  = bus.upd_valid && w_ready && !bus.clear_req;
    assign w_upd_idx = IDX_W'(lht_idx(bus.upd_pc, IDX_LSB, IDX_W));

    // Newest outcome enters at the MSB, oldest falls off the LSB.
    generate
        if (HIST_W == 1) begin : g_hist_1
            assign w_upd_hist = bus.upd_taken;
        end else begin : g_hist_n
            assign w_upd_hist = {bus.upd_taken, r_table[w_upd_idx][HIST_W-1:1]};
        end
    endgenerate

    // Storage is swept by the clear FSM rather than reset, so it stays a plain register file.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_table[w_clr_idx] <= '0;
        end else if (w_upd_we) begin
            r_table[w_upd_idx] <= w_upd_hist;
        end
    end

    generate
        for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
            logic [IDX_W-1:0] w_rd_idx;
            assign w_rd_idx       = IDX_W'(lht_idx(bus.rd_pc[g], IDX_LSB, IDX_W));
            assign bus.rd_hist[g] = w_ready ? r_table[w_rd_idx] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_local_history_table_mp.sv
// Directed bench for local_history_table_mp with a per-cycle reference model.
module tb_local_history_table_mp;
    localparam int ENTRIES = 1024;
    localparam int HIST_W  = 10;
    localparam int NUM_RD  = 2;
    localparam int IDX_LSB = 0;
    localparam int MAX_WAIT = 3000;

    logic clk;
    logic rst_n;

    local_history_table_mp_if #(.NUM_RD(NUM_RD), .HIST_W(HIST_W)) bus ();

    local_history_table_mp #(
        .ENTRIES (ENTRIES),
        .HIST_W  (HIST_W),
        .NUM_RD  (NUM_RD),
        .IDX_LSB (IDX_LSB)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole table zeroed on any reset/clear, becomes visible
    // once ENTRIES un-interrupted edges have elapsed.
    int unsigned model [ENTRIES];
    bit          m_ready;
    int          sweep_left;

    function automatic int unsigned m_idx(input logic [31:0] pc);
        return (int'(pc) >>> 0 == 0) ? 0 : ((pc >> IDX_LSB) % ENTRIES);
    endfunction

    function automatic void zero_model();
        for (int k = 0; k < ENTRIES; k++) model[k] = 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready    = 1'b0;
            sweep_left = ENTRIES;
            zero_model();
        end else if (bus.clear_req) begin
            m_ready    = 1'b0;
            sweep_left = ENTRIES;
            zero_model();
        end else if (!m_ready) begin
            sweep_left--;
            if (sweep_left == 0) m_ready = 1'b1;
        end else if (bus.upd_valid) begin
            int unsigned k;
            k = m_idx(bus.upd_pc);
            model[k] = (model[k] >> 1) | (int'(bus.upd_taken) << (HIST_W - 1));
        end
    end

    always @(negedge clk) begin
        check("ready", bus.ready, m_ready);
        for (int p = 0; p < NUM_RD; p++) begin
            check("rd_hist_model", bus.rd_hist[p], m_ready ? model[m_idx(bus.rd_pc[p])] : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready is seen; timeout shows up as a wrong count.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.ready && n < MAX_WAIT);
        check(name, n, ENTRIES);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.clear_req = 1'b0;
        bus.rd_pc     = '0;
        bus.upd_valid = 1'b0;
        bus.upd_pc    = '0;
        bus.upd_taken = 1'b0;

        repeat (3) step();
        check("reset_ready", bus.ready, 0);
        check("reset_rd_hist0", bus.rd_hist[0], 0);
        rst_n = 1'b1;
        wait_ready("init_latency");

        // Shift sequence on pc=5, pc=6 untouched
        bus.rd_pc[0]  = 32'd5;
        bus.rd_pc[1]  = 32'd6;
        bus.upd_valid = 1'b1;
        bus.upd_pc    = 32'd5;
        bus.upd_taken = 1'b1;
        step();
        check("pc5_t1", bus.rd_hist[0], 'h200);
        step();
        check("pc5_t2", bus.rd_hist[0], 'h300);
        step();
        check("pc5_t3", bus.rd_hist[0], 'h380);
        bus.upd_taken = 1'b0;
        step();
        check("pc5_nt", bus.rd_hist[0], 'h1C0);
        check("pc6_zero", bus.rd_hist[1], 0);

        // Same-cycle read and update, then aliasing
        bus.rd_pc[0]  = 32'd7;
        bus.rd_pc[1]  = 32'd7;
        bus.upd_pc    = 32'd7;
        bus.upd_taken = 1'b1;
        #1;
        check("pc7_same_cyc_p0", bus.rd_hist[0], 0);
        check("pc7_same_cyc_p1", bus.rd_hist[1], 0);
        step();
        bus.upd_valid = 1'b0;
        check("pc7_next_p0", bus.rd_hist[0], 'h200);
        check("pc7_next_p1", bus.rd_hist[1], 'h200);
        bus.rd_pc[0] = 32'h407;
        #1;
        check("alias_407", bus.rd_hist[0], 'h200);

        // clear_req with concurrent update; updates keep coming during INIT
        bus.clear_req = 1'b1;
        bus.upd_valid = 1'b1;
        bus.upd_pc    = 32'd5;
        bus.upd_taken = 1'b1;
        step();
        bus.clear_req = 1'b0;
        check("clear_ready_low", bus.ready, 0);
        wait_ready("clear_latency");
        bus.upd_valid = 1'b0;
        bus.rd_pc[0]  = 32'd5;
        bus.rd_pc[1]  = 32'd7;
        #1;
        check("after_clear_pc5", bus.rd_hist[0], 0);
        check("after_clear_pc7", bus.rd_hist[1], 0);

        // Reset mid-sweep at clr_idx=500
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        repeat (500) step();
        rst_n = 1'b0;
        #1;
        check("midsweep_reset_ready", bus.ready, 0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_ready("reset_restart_latency");

        // clear_req at clr_idx=10 restarts the sweep
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        repeat (10) step();
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        wait_ready("clear_restart_latency");

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/local_history_table_mp.md
# local_history_table_mp

Parametrised, multi-read-port local branch history table for the Tournament predictor. It holds one HIST_W-bit taken/not-taken shift history per PC-indexed entry. It serves NUM_RD combinational lookups per cycle and takes one explicitly qualified update per cycle. On reset or on request, a clear FSM zeroes the table one entry per cycle. It sits between fetch (lookup PCs) and resolve (update PC and outcome), and feeds the local prediction stage.

## Interface
- ENTRIES, 1024, number of history entries; power of two, at least 2; IDX_W = $clog2(ENTRIES)
- HIST_W, 10, history bits per entry; at least 1
- NUM_RD, 2, number of independent lookup ports; at least 1
- IDX_LSB, 0, lowest PC bit used for the index; index = pc[IDX_LSB +: IDX_W]
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear_req  in  1  request to rezero the whole table; honoured in any state
- rd_pc  in  NUM_RD x 32  lookup PC for each port
- rd_hist  out  NUM_RD x HIST_W  history for each lookup port
- upd_valid  in  1  a resolved conditional branch is presented this cycle
- upd_pc  in  32  PC of the resolved branch
- upd_taken  in  1  resolved outcome, 1 = taken
- ready  out  1  table is initialised; lookups are valid and updates are accepted

## Operation
- States: INIT, RUN.
- INIT writes 0 to entry clr_idx each cycle and then increments clr_idx.
  - When clr_idx = ENTRIES-1 has been written, the FSM moves to RUN on that edge.
- RUN moves to INIT with clr_idx = 0 when clear_req is sampled high.
- clear_req sampled high in INIT restarts the clear: clr_idx returns to 0.
- ready = (state == RUN). It is registered state, not decoded from inputs.
- Lookup: rd_hist[i] = table[idx(rd_pc[i])] when ready = 1, otherwise all zeros.
  - The lookup is purely combinational from rd_pc.
  - Ports are independent. Several ports may read the same index.
- Update: accepted only when upd_valid = 1 and state = RUN and clear_req = 0.
  - Accepted update: table[idx(upd_pc)] <= {upd_taken, table[idx(upd_pc)][HIST_W-1:1]}.
  - The newest outcome enters at the MSB. The oldest outcome leaves at the LSB.
- An update is silently dropped in INIT, or in the cycle clear_req is high.
- upd_taken and upd_pc are don't-care when upd_valid = 0. In that case the table is unchanged.
- PC bits outside [IDX_LSB +: IDX_W] are ignored, so aliasing entries share history.

## Timing
- Reset asserted (low) forces state = INIT, clr_idx = 0, ready = 0 and rd_hist = 0 immediately.
  - Table contents are not reset directly; the INIT sweep clears them.
- Release of reset starts the sweep on the first rising edge.
  - ready rises exactly ENTRIES edges after reset release.
- Lookup latency is 0 cycles.
- Update latency is 1 edge: a read of the same index in the update cycle returns the old value, and the next cycle returns the new value. There is no bypass.
- Reset asserted mid-INIT or mid-RUN aborts everything. The sweep restarts from entry 0 after release.
- clear_req has a cost of ENTRIES cycles of ready = 0 from the edge that samples it.
- The clr_idx counter is IDX_W+1 bits wide or compares against ENTRIES-1, so it never wraps silently.

## Structure
- The shared package lht_pkg holds:
  - the state enum lht_state_e {LHT_INIT, LHT_RUN};
  - the function lht_idx(pc), parameterised through the module's IDX_LSB and IDX_W.
- Sub-module lht_clear_fsm owns the state, clr_idx and ready. It outputs clr_we and clr_idx.
- The top level owns the storage array, write-port muxing (clear or update) and the NUM_RD read ports, built with a generate loop.
- The array is ENTRIES x HIST_W and is inferable as a multi-read, single-write register file.

## Test plan
- Reset low 3 cycles, then high, with ENTRIES=1024 → ready = 0 for 1024 edges and 1 on the 1024th. rd_hist = 0 throughout.
- In RUN, three taken updates to pc=5, then one not-taken → rd_hist for pc=5 reads 0x200, 0x300, 0x380, then 0x1C0 on successive cycles. pc=6 stays 0.
- Same-cycle read and update: rd_pc[0]=rd_pc[1]=7, upd pc=7, taken → both ports show 0 in that cycle and 0x200 next cycle. Separately, pc=0x407 aliases pc=7 (IDX_LSB=0) and reads 0x200.
- In RUN, clear_req pulses while upd_valid=1 → the update is dropped and ready = 0 for 1024 cycles. Afterwards, every previously written entry reads 0.
- Updates with upd_valid=1 during INIT → no entry changes; all reads after ready rises are 0.
- Reset asserted at clr_idx=500, then released → ready stays low for a full 1024 further cycles. clear_req at clr_idx=10 also restarts the count.
